cic_interp: RTL and testbench

Cascaded integrator-comb interpolator, the transmit-side counterpart of the receive CIC decimator. It accepts one low-rate sample per `strobe_in` and produces one high-rate sample per `strobe_out`, for an interpolation ratio R = `rate`+1. Processing order is N comb stages at the input rate, zero-stuffing, N integrator stages at the output rate, then gain normalisation. It sits between the transmit halfband/baseband path and the DAC interface in the TX chain.

---
 rtl/cic_interp_pkg.sv | 38 +++
 rtl/cic_int_shifter.sv | 25 ++
 rtl/cic_interp.sv | 78 +++++++
 tb/tb_cic_interp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cic_interp_pkg.sv
// Shared constants for the CIC interpolator: internal width and the
// rate-indexed gain-normalisation shift table.
package cic_interp_pkg;

  localparam int RATE_W   = 8;
  localparam int RATE_CNT = 1 << RATE_W;

  typedef logic [RATE_CNT-1:0][7:0] bg_tbl_t;

  function automatic int cic_width(int bw, int n, int l2);
    return bw + (n - 1) * l2;
  endfunction

  // ceil((n-1)*log2(r)): smallest b with 2^b >= r^(n-1)
  function automatic int bitgain(int n, int r);
    logic [63:0] p;
    int          b;
    p = 64'd1;
    for (int i = 0; i < n - 1; i++) p = p * 64'(r);
    b = 0;
    while (b < 63 && (64'd1 << b) < p) b++;
    return b;
  endfunction

  // Codes above the legal rate range clamp to the maximum-rate shift so
  // the slice never leaves the internal word.
  function automatic bg_tbl_t bitgain_table(int n, int l2);
    bg_tbl_t t;
    int      rr;
    t = '0;
    for (int r = 0; r < RATE_CNT; r++) begin
      rr   = (r + 1 > (1 << l2)) ? (1 << l2) : r + 1;
      t[r] = 8'(bitgain(n, rr));
    end
    return t;
  endfunction

endpackage

// File: rtl/cic_int_shifter.sv
// Gain normalisation: picks a bw-bit window of the W-bit integrator word,
// offset by the rate-dependent bitgain. Truncating, no rounding.
module cic_int_shifter
  import cic_interp_pkg::*;
#(
  parameter int bw            = 16,
  parameter int N             = 4,
  parameter int LOG2_MAX_RATE = 7
) (
  input  logic [RATE_W-1:0]                           rate_i,
  input  logic [cic_width(bw, N, LOG2_MAX_RATE)-1:0]  data_i,
  output logic [bw-1:0]                               data_o
);

  localparam bg_tbl_t BG = bitgain_table(N, LOG2_MAX_RATE);

  logic [bw-1:0] cand [RATE_CNT];

  for (genvar r = 0; r < RATE_CNT; r++) begin : g_slice
    assign cand[r] = data_i[int'(BG[r]) +: bw];
  end

  assign data_o = cand[rate_i];

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: N combs at the input rate, zero-stuffing, N integrators
// at the output rate, then a rate-selected gain-normalising slice.
module cic_interp
  import cic_interp_pkg::*;
#(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic              strobe_in,
  input  logic              strobe_out,
  input  logic [bw-1:0]     signal_in,
  output logic [bw-1:0]     signal_out
);

  localparam int W = cic_width(bw, N, log2_of_max_rate);

  logic                  clr;
  logic signed [W-1:0]   x_ext;
  logic [N-1:0][W-1:0]   diff_q, diff_d;
  logic [N-1:0][W-1:0]   pipe_q, pipe_d;
  logic [N-1:0][W-1:0]   integ_q, integ_d;
  logic [bw-1:0]         shift_out;

  assign clr   = reset | ~enable;
  assign x_ext = W'($signed(signal_in));

  always_comb begin
    diff_d = diff_q;
    pipe_d = pipe_q;
    if (strobe_in) begin
      diff_d[0] = x_ext;
      pipe_d[0] = x_ext - diff_q[0];
      for (int i = 1; i < N; i++) begin
        diff_d[i] = pipe_q[i-1];
        pipe_d[i] = pipe_q[i-1] - diff_q[i];
      end
    end
  end

  // Only a strobe_in coinciding with strobe_out injects; otherwise zeros.
  always_comb begin
    integ_d = integ_q;
    if (strobe_out) begin
      integ_d[0] = integ_q[0] + (strobe_in ? pipe_q[N-1] : '0);
      for (int i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
    end
  end

  cic_int_shifter #(
    .bw            (bw),
    .N             (N),
    .LOG2_MAX_RATE (log2_of_max_rate)
  ) u_shifter (
    .rate_i (rate),
    .data_i (integ_q[N-1]),
    .data_o (shift_out)
  );

  always_ff @(posedge clock) begin
    if (clr) begin
      diff_q     <= '0;
      pipe_q     <= '0;
      integ_q    <= '0;
      signal_out <= '0;
    end else begin
      diff_q     <= diff_d;
      pipe_q     <= pipe_d;
      integ_q    <= integ_d;
      signal_out <= shift_out;
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: directed DC/impulse/clear scenarios plus random
// streams, checked against a closed-form convolution model.
module tb_cic_interp;

  localparam int BW = 16;
  localparam int NS = 4;
  localparam int L2 = 7;
  localparam int W  = BW + (NS - 1) * L2;

  logic          clock = 1'b0;
  logic          reset, enable, strobe_in, strobe_out;
  logic [7:0]    rate;
  logic [BW-1:0] signal_in, signal_out;

  int npass = 0;
  int nchk  = 0;

  // Model state: input samples, per-strobe_out injections, strobe_out count.
  bit [63:0] xs[$];
  bit [63:0] us[$];
  int        ns;
  int        R;

  always #5 clock = ~clock;

  cic_interp #(.bw(BW), .N(NS), .log2_of_max_rate(L2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .strobe_out (strobe_out),
    .signal_in  (signal_in),
    .signal_out (signal_out)
  );

  function automatic bit [63:0] binom(int a, int b);
    bit [63:0] c;
    if (a < b) return 64'd0;
    c = 64'd1;
    for (int i = 0; i < b; i++) c = c * 64'(a - i) / 64'(i + 1);
    return c;
  endfunction

  function automatic int bench_shift(int r);
    bit [63:0] p;
    int        b;
    p = 64'd1;
    for (int i = 0; i < NS - 1; i++) p = p * 64'(r);
    b = 0;
    while ((64'd1 << b) < p) b++;
    return b;
  endfunction

  // N cascaded accumulators: response to an injection n-1-s strobes ago is C(n-1-s, N-1).
  function automatic logic [BW-1:0] model_out(int n);
    bit [63:0] e;
    e = 64'd0;
    for (int s = 0; s < n; s++) e += us[s] * binom(n - 1 - s, NS - 1);
    e &= (64'd1 << W) - 64'd1;
    return BW'(e >> bench_shift(R));
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] expv);
    nchk++;
    assert (signal_out === expv) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(signal_out), $signed(expv));
  endtask

  // Clear via enable (also loads a new rate) or via reset; strobes are live to prove they are ignored.
  task automatic clear(input bit use_en, input int r, input string tag);
    if (use_en) begin
      enable = 1'b0;
      rate   = 8'(r);
    end else begin
      reset = 1'b1;
    end
    strobe_in  = 1'b1;
    strobe_out = 1'b1;
    signal_in  = BW'($urandom);
    @(posedge clock); #1;
    check(tag, '0);
    reset  = 1'b0;
    enable = 1'b1;
    xs.delete();
    us.delete();
    ns = 0;
    R  = int'(rate) + 1;
  endtask

  task automatic step(input logic [BW-1:0] x, input string tag);
    bit        sin;
    int        k, m;
    bit [63:0] u, t;
    sin        = (ns % R == 0);
    strobe_in  = sin;
    strobe_out = 1'b1;
    signal_in  = sin ? x : BW'($urandom);
    if (sin) begin
      xs.push_back(64'($signed(x)));
      k = xs.size() - 1;
      u = 64'd0;
      // N-th difference of the input sequence, N samples late
      for (int j = 0; j <= NS; j++) begin
        m = k - NS - j;
        if (m >= 0) begin
          t = binom(NS, j) * xs[m];
          u = (j % 2 == 1) ? u - t : u + t;
        end
      end
      us.push_back(u);
    end else begin
      us.push_back(64'd0);
    end
    @(posedge clock); #1;
    check(tag, model_out(ns));
    ns++;
  endtask

  task automatic idle(input string tag);
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
    signal_in  = BW'($urandom);
    @(posedge clock); #1;
    check(tag, model_out(ns));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; rate = 8'd0;
    strobe_in = 1'b0; strobe_out = 1'b0; signal_in = '0;
    ns = 0; R = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", '0);
    reset = 1'b0;

    // DC at R=1, 2, 4, 3 and full scale at max rate
    clear(1'b1, 0, "clr_r1");
    for (int i = 0; i < 3 * NS; i++) begin
      step(16'd100, "dc_r1");
      if (i >= 2 * NS) check("dc_r1_const", 16'd100);
    end
    clear(1'b1, 1, "clr_r2");
    repeat ((2 * NS + 2) * 2) step(16'd100, "dc_r2");
    check("dc_r2_const", 16'd100);
    clear(1'b1, 3, "clr_r4");
    repeat ((2 * NS + 2) * 4) step(16'd100, "dc_r4");
    check("dc_r4_const", 16'd100);
    clear(1'b1, 2, "clr_r3");
    repeat ((2 * NS + 2) * 3) step(16'd1000, "dc_r3");
    check("dc_r3_const", 16'd843);
    clear(1'b1, 127, "clr_r128");
    repeat ((2 * NS + 2) * 128) step(16'h8000, "fullscale_r128");
    check("fullscale_const", 16'h8000);

    // Impulse at R=1: sample at clock 0 appears only at clock 2N
    clear(1'b1, 0, "clr_imp");
    for (int i = 0; i < 3 * NS; i++) begin
      step((i == 0) ? 16'd1000 : 16'd0, "impulse");
      check("impulse_const", (i == 2 * NS) ? 16'd1000 : 16'd0);
    end

    // Random streams, one with strobe_out gaps
    clear(1'b1, 1, "clr_rand2");
    for (int i = 0; i < 60; i++) begin
      step(BW'($urandom), "rand_r2_gaps");
      if ($urandom_range(0, 2) == 0) idle("rand_r2_idle");
    end
    clear(1'b1, 5, "clr_rand6");
    repeat (80) step(BW'($urandom), "rand_r6");
    clear(1'b1, 2, "clr_rand3");
    repeat (50) step(BW'($urandom), "rand_r3");

    // Mid-stream clear by reset, then by enable; zeros must stay zero
    clear(1'b1, 1, "clr_mid");
    repeat (30) step(BW'($urandom), "mid_pre_reset");
    clear(1'b0, 1, "mid_reset");
    for (int i = 0; i < 30; i++) begin
      step(16'd0, "mid_post_reset");
      check("mid_reset_zero", 16'd0);
    end
    repeat (30) step(BW'($urandom), "mid_pre_enable");
    clear(1'b1, 1, "mid_enable");
    for (int i = 0; i < 30; i++) begin
      step(16'd0, "mid_post_enable");
      check("mid_enable_zero", 16'd0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
